hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the `stall` and `clear` inputs of the four stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold signal. It resolves these events into one consistent per-cycle control vector:

- load-use hazards
- taken-branch/jump redirects
- instruction-memory waits
- data-memory waits

A small FSM tracks wrong-path fetches that are still in flight. Two performance counters record stall and flush activity.

## Interface
Parameters:
- `REGW`, default 5: register-index width.
- `CNTW`, default 32: performance counter width.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2`, in, `REGW` each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`, in, 1 each: the ID instruction actually reads that source.
- `ex_is_load`, in, 1: the instruction in EX is a load.
- `ex_rd`, in, `REGW`: destination register of the instruction in EX.
- `ex_redirect`, in, 1: EX resolved a taken branch or jump. The PC mux selects the target this cycle.
- `imem_req`, `imem_resp`, in, 1 each: fetch request outstanding / response valid this cycle.
- `dmem_req`, `dmem_resp`, in, 1 each: MEM-stage access outstanding / response valid this cycle.
- `pc_stall`, out, 1: hold the PC.
- `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb`, out, 1 each: hold the corresponding pipeline register.
- `clear_if_id`, `clear_id_ex`, `clear_ex_mem`, `clear_mem_wb`, out, 1 each: load a bubble (all zeros) into the corresponding pipeline register.
- `stall_cycles`, out, `CNTW`: count of cycles with `pc_stall`=1.
- `flush_count`, out, `CNTW`: count of accepted redirects.

## Operation
Derived conditions, evaluated each cycle:
- `dwait` = `dmem_req` & ~`dmem_resp`
- `iwait` = `imem_req` & ~`imem_resp`
- `luh` = `ex_is_load` & (`ex_rd` != 0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`))

FSM states:
- **RUN**: normal operation.
- **IKILL**: a wrong-path fetch is in flight and its response must be discarded.

Control priority in RUN (first match wins). Any output not listed is 0.
1. `dwait`:
   - Assert `pc_stall`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`.
   - Assert `clear_mem_wb`, so WB sees a bubble and does not write back twice.
   - `ex_redirect` is ignored in this cycle. EX is frozen, so the redirect is presented again once the wait ends.
2. `ex_redirect`:
   - Assert `clear_if_id` and `clear_id_ex`. `pc_stall`=0, so the PC loads the target.
   - `flush_count` += 1.
   - If `iwait` is also true, go to IKILL.
   - This priority level takes precedence over both `luh` and `iwait`.
3. `luh`:
   - Assert `pc_stall` and `stall_if_id`.
   - Assert `clear_id_ex`, inserting exactly one bubble.
4. `iwait`:
   - Assert `pc_stall` and `clear_if_id`. ID receives bubbles; downstream stages keep advancing.

Control in IKILL:
- Assert `pc_stall` and `clear_if_id` every cycle, whether or not `imem_resp` arrives.
- When `imem_resp`=1 (the stale response), return to RUN. That response is discarded by `clear_if_id`.
- `dwait` takes precedence: apply the rule-1 outputs but stay in IKILL.
- An `ex_redirect` in IKILL is impossible by construction: ID/EX was cleared and `clear_if_id` holds. If it is asserted anyway, apply rule 2 and remain in IKILL.

Counters:
- `stall_cycles` increments on every edge where `pc_stall`=1 and `rst_n`=1.
- Both counters wrap modulo 2^`CNTW`.

Reset (`rst_n`=0):
- State goes to RUN and both counters go to 0 immediately, independent of `clk`.
- While `rst_n` is low, outputs are forced to: all `clear_*`=1, all `stall_*`=0, `pc_stall`=1. The pipeline registers therefore flush to bubbles on every edge during reset.
- Reset mid-IKILL abandons the kill. The memory interface is reset alongside this block.

## Timing
- All `stall_*`, `clear_*` and `pc_stall` outputs are combinational from the current state and inputs. They take effect at the next rising edge; there is zero cycle latency from a hazard to its control.
- The FSM state and counters are registered. The counter outputs reflect events up to and including the previous edge.
- A load-use stall lasts exactly one cycle. At the next edge the load moves to MEM and `luh` drops. If the load's own `dwait` then occurs, rule 1 governs.
- A stall always wins over a clear on the same register. Only MEM/WB is cleared during `dwait`.
- `imem_resp` and `dmem_resp` arriving in the same cycle as their request count as no wait.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → every cycle shows all `clear_*`=1 and `pc_stall`=1. Release reset → state RUN, both counters 0, all outputs 0 with idle inputs.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for one cycle → `pc_stall`=`stall_if_id`=`clear_id_ex`=1 for that cycle only, `stall_cycles`=1. Repeat with `ex_rd`=0 → no stall.
- **Redirect:** pulse `ex_redirect` → `clear_if_id`=`clear_id_ex`=1, `pc_stall`=0, `flush_count`=1. Pulse `ex_redirect` together with `luh` → same outputs, no stall.
- **Redirect during fetch wait:** `imem_req`=1, `imem_resp`=0, pulse `ex_redirect` → FSM enters IKILL. `pc_stall`=`clear_if_id`=1 for 4 cycles until `imem_resp`=1, then RUN on the following edge.
- **Data wait:** `dwait` for 6 cycles while `ex_redirect`=1 → PC, IF/ID, ID/EX, EX/MEM stalled; `clear_mem_wb`=1; no flush; `stall_cycles`=6. Redirect accepted on the first cycle after `dmem_resp`.
- **Counter wrap:** with `CNTW`=4, 17 stall cycles → `stall_cycles`=1.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for a 5-stage pipeline. It turns load-use, redirect and memory-wait
// events into one stall/clear vector per cycle and tracks wrong-path fetches still in flight.
module hazard_control_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_redirect,
  input  logic            imem_req,
  input  logic            imem_resp,
  input  logic            dmem_req,
  input  logic            dmem_resp,
  output logic            pc_stall,
  output logic            stall_if_id,
  output logic            stall_id_ex,
  output logic            stall_ex_mem,
  output logic            stall_mem_wb,
  output logic            clear_if_id,
  output logic            clear_id_ex,
  output logic            clear_ex_mem,
  output logic            clear_mem_wb,
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_count
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_IKILL = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_stall_cycles;
  logic [CNTW-1:0] r_flush_count;
  logic            w_dwait;
  logic            w_iwait;
  logic            w_luh;
  logic            w_redirect_taken;

  assign w_dwait = dmem_req & ~dmem_resp;
  assign w_iwait = imem_req & ~imem_resp;
  assign w_luh   = ex_is_load & (ex_rd != '0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_stall         = 1'b0;
    stall_if_id      = 1'b0;
    stall_id_ex      = 1'b0;
    stall_ex_mem     = 1'b0;
    stall_mem_wb     = 1'b0;
    clear_if_id      = 1'b0;
    clear_id_ex      = 1'b0;
    clear_ex_mem     = 1'b0;
    clear_mem_wb     = 1'b0;
    w_redirect_taken = 1'b0;
    w_state_nxt      = r_state;
    if (!rst_n) begin
      // Flush every pipeline register to a bubble on each edge while reset is held
      pc_stall     = 1'b1;
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_ex_mem = 1'b1;
      clear_mem_wb = 1'b1;
      w_state_nxt  = ST_RUN;
    end else if (w_dwait) begin
      // EX is frozen, so a pending redirect is presented again once the wait ends
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      clear_mem_wb = 1'b1;
    end else if (ex_redirect) begin
      clear_if_id      = 1'b1;
      clear_id_ex      = 1'b1;
      w_redirect_taken = 1'b1;
      if (w_iwait) begin
        w_state_nxt = ST_IKILL;
      end
    end else if (r_state == ST_IKILL) begin
      // The stale response is discarded by the IF/ID clear in the same cycle
      pc_stall    = 1'b1;
      clear_if_id = 1'b1;
      if (imem_resp) begin
        w_state_nxt = ST_RUN;
      end
    end else if (w_luh) begin
      pc_stall    = 1'b1;
      stall_if_id = 1'b1;
      clear_id_ex = 1'b1;
    end else if (w_iwait) begin
      pc_stall    = 1'b1;
      clear_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (pc_stall) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
      if (w_redirect_taken) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: directed scenarios and random traffic, checked against a
// priority-table reference model. A second instance with CNTW=4 covers counter wrap.
module tb_hazard_control_unit;
  localparam int REGW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REGW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_redirect = 0;
  logic imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;

  logic pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
  logic [31:0] stall_cycles, flush_count;
  logic n_pc_stall, n_stall_if_id, n_stall_id_ex, n_stall_ex_mem, n_stall_mem_wb;
  logic n_clear_if_id, n_clear_id_ex, n_clear_ex_mem, n_clear_mem_wb;
  logic [3:0] n_stall_cycles, n_flush_count;

  hazard_control_unit #(.REGW(REGW), .CNTW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .pc_stall(pc_stall),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .stall_mem_wb(stall_mem_wb), .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex),
    .clear_ex_mem(clear_ex_mem), .clear_mem_wb(clear_mem_wb),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_control_unit #(.REGW(REGW), .CNTW(4)) u_dut_narrow (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .pc_stall(n_pc_stall),
    .stall_if_id(n_stall_if_id), .stall_id_ex(n_stall_id_ex), .stall_ex_mem(n_stall_ex_mem),
    .stall_mem_wb(n_stall_mem_wb), .clear_if_id(n_clear_if_id), .clear_id_ex(n_clear_id_ex),
    .clear_ex_mem(n_clear_ex_mem), .clear_mem_wb(n_clear_mem_wb),
    .stall_cycles(n_stall_cycles), .flush_count(n_flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which rule wins this cycle, and the control word each rule implies.
  // Control word bit order: {pc, stall IF/ID, ID/EX, EX/MEM, MEM/WB, clear IF/ID, ID/EX, EX/MEM, MEM/WB}
  bit           m_kill = 0;
  longint unsigned m_stalls = 0;
  longint unsigned m_flushes = 0;
  logic [8:0]   ctrl_tbl [7];

  initial begin
    ctrl_tbl[0] = 9'b1_0000_1111;  // reset
    ctrl_tbl[1] = 9'b1_1110_0001;  // data wait
    ctrl_tbl[2] = 9'b0_0000_1100;  // redirect
    ctrl_tbl[3] = 9'b1_0000_1000;  // killing stale fetch
    ctrl_tbl[4] = 9'b1_1000_0100;  // load-use
    ctrl_tbl[5] = 9'b1_0000_1000;  // fetch wait
    ctrl_tbl[6] = 9'b0_0000_0000;  // idle
  end

  function automatic int winner();
    bit dw = dmem_req && !dmem_resp;
    bit lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n)      return 0;
    if (dw)          return 1;
    if (ex_redirect) return 2;
    if (m_kill)      return 3;
    if (lu)          return 4;
    if (imem_req && !imem_resp) return 5;
    return 6;
  endfunction

  function automatic logic [8:0] obs_ctrl();
    return {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb};
  endfunction

  function automatic logic [8:0] obs_ctrl_n();
    return {n_pc_stall, n_stall_if_id, n_stall_id_ex, n_stall_ex_mem, n_stall_mem_wb,
            n_clear_if_id, n_clear_id_ex, n_clear_ex_mem, n_clear_mem_wb};
  endfunction

  // Inputs are set right after a falling edge; this checks, then advances to the next falling edge.
  task automatic cycle();
    int w;
    #1;
    if (!rst_n) begin
      m_kill = 0; m_stalls = 0; m_flushes = 0;
    end
    w = winner();
    check("ctrl", 64'(obs_ctrl()), 64'(ctrl_tbl[w]));
    check("ctrl_narrow", 64'(obs_ctrl_n()), 64'(ctrl_tbl[w]));
    check("stall_cycles", 64'(stall_cycles), m_stalls % 64'h1_0000_0000);
    check("flush_count", 64'(flush_count), m_flushes % 64'h1_0000_0000);
    check("stall_cycles_w4", 64'(n_stall_cycles), m_stalls % 16);
    check("flush_count_w4", 64'(n_flush_count), m_flushes % 16);
    if (rst_n) begin
      if (ctrl_tbl[w][8]) m_stalls++;
      if (w == 2) begin
        m_flushes++;
        if (imem_req && !imem_resp) m_kill = 1;
      end
      if (w == 3 && imem_resp) m_kill = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    ex_redirect = 0; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    repeat (n) cycle();
    rst_n = 1;
  endtask

  task automatic load_use(input logic [REGW-1:0] rd);
    ex_is_load = 1; ex_rd = rd; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  logic [31:0] s0, f0;

  initial begin
    idle();
    @(negedge clk);
    do_reset(3);

    cycle();
    check("post_reset_cnt", 64'(stall_cycles), 64'd0);

    // Load-use, then the same with ex_rd = 0
    load_use(5); cycle();
    idle(); cycle();
    check("lu_stall_cnt", 64'(stall_cycles), 64'd1);
    load_use(0); cycle();
    idle(); cycle();
    check("lu_rd0_cnt", 64'(stall_cycles), 64'd1);

    // Redirect alone, then redirect on top of a load-use hazard
    ex_redirect = 1; cycle();
    idle(); cycle();
    check("redir_flush", 64'(flush_count), 64'd1);
    load_use(5); ex_redirect = 1; cycle();
    idle(); cycle();
    check("redir_lu_flush", 64'(flush_count), 64'd2);
    check("redir_lu_stall", 64'(stall_cycles), 64'd1);

    // Redirect during a fetch wait: four kill cycles, the last carrying the stale response
    imem_req = 1; ex_redirect = 1; cycle();
    ex_redirect = 0;
    repeat (3) cycle();
    imem_resp = 1;
    #1 check("ikill_resp_pc", 64'(pc_stall), 64'd1);
    cycle();
    idle(); cycle();
    check("ikill_back_to_run", 64'(obs_ctrl()), 64'd0);

    // Data wait with redirect held: no flush during the wait, redirect taken once it ends
    s0 = stall_cycles; f0 = flush_count;
    dmem_req = 1; ex_redirect = 1;
    repeat (6) cycle();
    check("dwait_no_flush", 64'(flush_count), 64'(f0));
    check("dwait_stalls", 64'(stall_cycles - s0), 64'd6);
    dmem_resp = 1; cycle();
    idle(); cycle();
    check("dwait_redir_after", 64'(flush_count), 64'(f0 + 1));

    // Reset in the middle of a kill abandons it
    imem_req = 1; ex_redirect = 1; cycle();
    ex_redirect = 0; cycle();
    idle(); do_reset(1);
    cycle();
    check("reset_mid_kill", 64'(obs_ctrl()), 64'd0);

    // Counter wrap on the narrow instance: 17 stall cycles
    do_reset(1);
    imem_req = 1;
    repeat (17) cycle();
    idle(); cycle();
    check("wrap_w4", 64'(n_stall_cycles), 64'd1);
    check("wrap_w32", 64'(stall_cycles), 64'd17);

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 4000; i++) begin
      id_rs1      = REGW'($urandom_range(0, 3));
      id_rs2      = REGW'($urandom_range(0, 3));
      ex_rd       = REGW'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 5) == 0);
      imem_req    = ($urandom_range(0, 2) != 0);
      imem_resp   = ($urandom_range(0, 2) == 0);
      dmem_req    = ($urandom_range(0, 4) == 0);
      dmem_resp   = ($urandom_range(0, 1) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      cycle();
      rst_n = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
